ldu_dcache_bank_req_receiver: RTL and testbench
===============================================

Name: ldu_dcache_bank_req_receiver

Overview:
Responder end of the load-unit REQ interface for one dcache bank; one instance per bank, with BANK_ID selecting the bank. It accepts load requests (first half and misaligned second half) into a small FIFO and presents them in order to the bank tag-lookup stage. It drives the registered REQ_early_ready feedback from its own occupancy and from the bank stall sources, so the sender can compute its ack without a combinational loop.

Parameters:
BANK_ID, 0, bank served; every accepted REQ_PO_word[DCACHE_WORD_ADDR_BANK_BIT] must equal this.
REQ_BUFFER_SIZE, 2, FIFO depth in entries; must be >= 2.
VPN_WIDTH, 20, virtual page number width.
PO_WIDTH, 12, page offset width in bytes.
LOG_LDU_CQ_ENTRIES, 4, CQ index width.

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high, sampled on posedge CLK
REQ_valid  in  1  bank-specific request valid (REQ_bankN_valid)
REQ_is_mq  in  1  request is the misaligned second half
REQ_misaligned  in  1  first half of a misaligned load
REQ_VPN  in  VPN_WIDTH  virtual page number
REQ_PO_word  in  PO_WIDTH-2  word offset within the page
REQ_byte_mask  in  4  byte lanes
REQ_cq_index  in  LOG_LDU_CQ_ENTRIES  CQ entry
REQ_early_ready  out  1  registered ready to the sender
bank_stall  in  1  WB, exception or mispredict stall; blocks new accepts
mshr_full  in  1  MSHRs full; blocks new accepts
flush  in  1  drop every buffered request
deq_valid  out  1  head entry valid to tag stage
deq_is_mq, deq_misaligned, deq_VPN, deq_PO_word, deq_byte_mask, deq_cq_index  out  as inputs  head entry fields
deq_ready  in  1  tag stage takes head
count  out  $clog2(REQ_BUFFER_SIZE+1)  occupancy
mq_pending  out  1  head or a younger entry is a first half whose is_mq partner has not yet been accepted

Behaviour:
- Accept: enq = REQ_valid & REQ_early_ready & ~flush. No other qualifier is applied; the sender guarantees that valid stays held until ack.
- REQ_valid & ~REQ_early_ready: the request is ignored, not enqueued. The sender re-presents it.
- Dequeue: deq = deq_valid & deq_ready & ~flush. deq_valid = (count != 0), with no bypass: an enqueued entry is visible the next cycle at the earliest.
- Enqueue and dequeue in the same cycle: count is unchanged. Order is strict FIFO; pointers wrap modulo REQ_BUFFER_SIZE.
- count_next = flush ? 0 : count + enq - deq.
- REQ_early_ready is a register: next = ~bank_stall & ~mshr_full & (count_next < REQ_BUFFER_SIZE). Stall or mshr_full therefore takes effect exactly one cycle later. Overflow is impossible because the sender enqueues at most 1 per cycle and only while REQ_early_ready is 1.
- mq_pending register:
  - set on enq with REQ_misaligned & ~REQ_is_mq;
  - cleared on enq with REQ_is_mq, or on flush;
  - the set takes precedence over a stale value.
- If an is_mq request is accepted while mq_pending = 0, it is still enqueued, and the sticky bit protocol_err is set in count's debug shadow (not a port; a simulation assertion fires).
- Flush:
  - on the flush cycle, head, tail and count are zeroed;
  - any REQ_valid that cycle is dropped;
  - deq_valid is 0 from the next cycle;
  - REQ_early_ready next = ~bank_stall & ~mshr_full.
- Reset:
  - count = 0, pointers = 0, deq_valid = 0, mq_pending = 0, REQ_early_ready = 0, and all deq_* fields read 0;
  - the first post-reset cycle computes REQ_early_ready = 1, visible the cycle after RST deasserts if no stall;
  - a reset mid-operation discards all entries identically to flush.
- A full FIFO with deq in the same cycle yields count_next = SIZE-1, so REQ_early_ready goes to 1 next cycle.

Test Plan:
- Reset, then idle: REQ_early_ready = 0 in the reset cycle and 1 one cycle later; count = 0; deq_valid = 0.
- Three back-to-back requests with cq_index 1, 2, 3 and deq_ready = 0, SIZE = 2: first two accepted, count = 2, REQ_early_ready falls after the second accept, third held. Then raise deq_ready: deq order is 1, 2, then 3 once re-accepted.
- Misaligned pair: first half (misaligned = 1, VPN = 0x12345, PO_word = 0x3FF, mask = 4'b1110), then is_mq (VPN = 0x12346, PO_word = 0x000, mask = 4'b0001): mq_pending rises and then clears; both are dequeued in order.
- Pulse bank_stall for one cycle with FIFO empty: REQ_early_ready = 0 for exactly the following cycle; a REQ_valid in that cycle is not enqueued.
- FIFO full, simultaneous enq attempt and deq: no enqueue (ready = 0); count goes to 1; ready = 1 next cycle.
- Flush with count = 2 and REQ_valid = 1: count = 0, deq_valid = 0, mq_pending = 0 next cycle; REQ_early_ready = 1 the cycle after.

Source files
------------

// File: rtl/ldu_dcache_bank_req_receiver.sv
// ============================================================================
//  Module      : ldu_dcache_bank_req_receiver
//  Description : Responder end of the load-unit REQ interface for one dcache
//                bank. Buffers accepted load requests (first halves and
//                misaligned second halves) in a small in-order FIFO, presents
//                the head to the bank tag-lookup stage and drives a registered
//                early-ready back to the sender.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldu_dcache_bank_req_receiver #(
    parameter int BANK_ID                   = 0,
    parameter int REQ_BUFFER_SIZE           = 2,
    parameter int VPN_WIDTH                 = 20,
    parameter int PO_WIDTH                  = 12,
    parameter int LOG_LDU_CQ_ENTRIES        = 4,
    parameter int DCACHE_WORD_ADDR_BANK_BIT = 0,
    parameter int BANK_CHECK_EN             = 0
) (
    input  logic                                   CLK,
    input  logic                                   RST,

    input  logic                                   REQ_valid,
    input  logic                                   REQ_is_mq,
    input  logic                                   REQ_misaligned,
    input  logic [VPN_WIDTH-1:0]                   REQ_VPN,
    input  logic [PO_WIDTH-3:0]                    REQ_PO_word,
    input  logic [3:0]                             REQ_byte_mask,
    input  logic [LOG_LDU_CQ_ENTRIES-1:0]          REQ_cq_index,
    output logic                                   REQ_early_ready,

    input  logic                                   bank_stall,
    input  logic                                   mshr_full,
    input  logic                                   flush,

    output logic                                   deq_valid,
    output logic                                   deq_is_mq,
    output logic                                   deq_misaligned,
    output logic [VPN_WIDTH-1:0]                   deq_VPN,
    output logic [PO_WIDTH-3:0]                    deq_PO_word,
    output logic [3:0]                             deq_byte_mask,
    output logic [LOG_LDU_CQ_ENTRIES-1:0]          deq_cq_index,
    input  logic                                   deq_ready,

    output logic [$clog2(REQ_BUFFER_SIZE+1)-1:0]   count,
    output logic                                   mq_pending
);

    localparam int CNT_W = $clog2(REQ_BUFFER_SIZE + 1);
    localparam int PTR_W = $clog2(REQ_BUFFER_SIZE);
    localparam int ENT_W = 2 + VPN_WIDTH + (PO_WIDTH - 2) + 4 + LOG_LDU_CQ_ENTRIES;

    // Entry storage; only the occupied window [head, head+count) is meaningful.
    logic [ENT_W-1:0] r_mem [REQ_BUFFER_SIZE];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_ready;
    logic             r_mq_pending;
    logic             r_protocol_err;

    logic             w_enq;
    logic             w_deq;
    logic [CNT_W-1:0] w_count_next;
    logic [ENT_W-1:0] w_enq_entry;
    logic [ENT_W-1:0] w_head_entry;

    // Pointer advance with wrap at the buffer depth (depth need not be 2^n).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(REQ_BUFFER_SIZE - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake qualification and occupancy update.
    always_comb begin
        w_enq        = REQ_valid & r_ready & ~flush;
        w_deq        = (r_count != '0) & deq_ready & ~flush;
        w_count_next = flush ? '0 : (r_count + CNT_W'(w_enq) - CNT_W'(w_deq));
        w_enq_entry  = {REQ_is_mq, REQ_misaligned, REQ_VPN, REQ_PO_word,
                        REQ_byte_mask, REQ_cq_index};
        // Fields are forced to zero while empty so the head never shows stale data.
        w_head_entry = (r_count != '0) ? r_mem[r_head] : '0;
    end

    assign deq_valid       = (r_count != '0);
    assign {deq_is_mq, deq_misaligned, deq_VPN, deq_PO_word,
            deq_byte_mask, deq_cq_index} = w_head_entry;
    assign count           = r_count;
    assign REQ_early_ready = r_ready;
    assign mq_pending      = r_mq_pending;

    // Write accepted request at the tail slot.
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_mem[r_tail] <= w_enq_entry;
        end
    end

    // Pointers, occupancy, registered ready and misaligned-pair tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_ready        <= 1'b0;
            r_mq_pending   <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_count <= w_count_next;
            // Ready looks at next occupancy so the sender never overfills us.
            r_ready <= ~bank_stall & ~mshr_full &
                       (w_count_next < CNT_W'(REQ_BUFFER_SIZE));

            if (flush) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_enq) r_tail <= ptr_inc(r_tail);
                if (w_deq) r_head <= ptr_inc(r_head);
            end

            // A new first half sets pending even if a stale value is present.
            if (flush) begin
                r_mq_pending <= 1'b0;
            end else if (w_enq & REQ_misaligned & ~REQ_is_mq) begin
                r_mq_pending <= 1'b1;
            end else if (w_enq & REQ_is_mq) begin
                r_mq_pending <= 1'b0;
            end

            // Second half arriving without an outstanding first half.
            if (w_enq & REQ_is_mq & ~r_mq_pending) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // Simulation checks on sender protocol and bank routing.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!r_protocol_err);
            if (BANK_CHECK_EN != 0 && w_enq) begin
                assert (REQ_PO_word[DCACHE_WORD_ADDR_BANK_BIT] == 1'(BANK_ID));
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ldu_dcache_bank_req_receiver.sv
// ============================================================================
//  Module      : tb_ldu_dcache_bank_req_receiver
//  Description : Directed, table-driven bench for the dcache bank request
//                receiver (depth 2), with hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ldu_dcache_bank_req_receiver;

    localparam int SIZE = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_valid, REQ_is_mq, REQ_misaligned;
    logic [19:0] REQ_VPN;
    logic [9:0]  REQ_PO_word;
    logic [3:0]  REQ_byte_mask;
    logic [3:0]  REQ_cq_index;
    logic        REQ_early_ready;
    logic        bank_stall, mshr_full, flush;
    logic        deq_valid, deq_is_mq, deq_misaligned;
    logic [19:0] deq_VPN;
    logic [9:0]  deq_PO_word;
    logic [3:0]  deq_byte_mask;
    logic [3:0]  deq_cq_index;
    logic        deq_ready;
    logic [1:0]  count;
    logic        mq_pending;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    ldu_dcache_bank_req_receiver #(
        .BANK_ID(0), .REQ_BUFFER_SIZE(SIZE), .VPN_WIDTH(20),
        .PO_WIDTH(12), .LOG_LDU_CQ_ENTRIES(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ_valid(REQ_valid), .REQ_is_mq(REQ_is_mq), .REQ_misaligned(REQ_misaligned),
        .REQ_VPN(REQ_VPN), .REQ_PO_word(REQ_PO_word), .REQ_byte_mask(REQ_byte_mask),
        .REQ_cq_index(REQ_cq_index), .REQ_early_ready(REQ_early_ready),
        .bank_stall(bank_stall), .mshr_full(mshr_full), .flush(flush),
        .deq_valid(deq_valid), .deq_is_mq(deq_is_mq), .deq_misaligned(deq_misaligned),
        .deq_VPN(deq_VPN), .deq_PO_word(deq_PO_word), .deq_byte_mask(deq_byte_mask),
        .deq_cq_index(deq_cq_index), .deq_ready(deq_ready),
        .count(count), .mq_pending(mq_pending)
    );

    typedef struct {
        logic       valid;
        logic       mis;
        logic [3:0] cq;
        logic       stall;
        logic       mshr;
        logic       fl;
        logic       dr;
        logic       exp_rdy;
        logic [1:0] exp_cnt;
        logic       exp_dv;
        logic [3:0] exp_cq;
        logic       exp_mq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic valid, input logic mis, input logic [3:0] cq,
                                input logic stall, input logic mshr, input logic fl,
                                input logic dr, input logic exp_rdy, input logic [1:0] exp_cnt,
                                input logic exp_dv, input logic [3:0] exp_cq, input logic exp_mq);
        vec_t v;
        v.valid = valid; v.mis = mis; v.cq = cq; v.stall = stall; v.mshr = mshr;
        v.fl = fl; v.dr = dr; v.exp_rdy = exp_rdy; v.exp_cnt = exp_cnt;
        v.exp_dv = exp_dv; v.exp_cq = exp_cq; v.exp_mq = exp_mq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        REQ_valid = 0; REQ_is_mq = 0; REQ_misaligned = 0; REQ_VPN = '0;
        REQ_PO_word = '0; REQ_byte_mask = '0; REQ_cq_index = '0;
        bank_stall = 0; mshr_full = 0; flush = 0; deq_ready = 0;
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();

        // Columns: valid mis cq stall mshr flush deq_ready | rdy cnt dv cq mq
        // Back-to-back cq 1,2,3 into a depth-2 buffer, then drain in order.
        vecs.push_back(mk(1,0, 1, 0,0,0,0, 1,2'd1,1, 1,0));
        vecs.push_back(mk(1,0, 2, 0,0,0,0, 0,2'd2,1, 1,0));
        vecs.push_back(mk(1,0, 3, 0,0,0,0, 0,2'd2,1, 1,0));
        vecs.push_back(mk(1,0, 3, 0,0,0,1, 1,2'd1,1, 2,0));
        vecs.push_back(mk(1,0, 3, 0,0,0,1, 1,2'd1,1, 3,0));
        vecs.push_back(mk(0,0, 0, 0,0,0,1, 1,2'd0,0, 0,0));
        // One-cycle bank_stall: ready low for exactly one cycle, request ignored.
        vecs.push_back(mk(0,0, 0, 1,0,0,0, 0,2'd0,0, 0,0));
        vecs.push_back(mk(1,0, 7, 0,0,0,0, 1,2'd0,0, 0,0));
        vecs.push_back(mk(0,0, 0, 0,0,0,0, 1,2'd0,0, 0,0));
        // One-cycle mshr_full.
        vecs.push_back(mk(0,0, 0, 0,1,0,0, 0,2'd0,0, 0,0));
        vecs.push_back(mk(0,0, 0, 0,0,0,0, 1,2'd0,0, 0,0));
        // Fill, then enq attempt with deq while full (pointers wrap here).
        vecs.push_back(mk(1,0, 8, 0,0,0,0, 1,2'd1,1, 8,0));
        vecs.push_back(mk(1,0, 9, 0,0,0,0, 0,2'd2,1, 8,0));
        vecs.push_back(mk(1,0,10, 0,0,0,1, 1,2'd1,1, 9,0));
        vecs.push_back(mk(0,0, 0, 0,0,0,1, 1,2'd0,0, 0,0));
        // Flush with two entries, a pending first half and a valid request.
        vecs.push_back(mk(1,1,11, 0,0,0,0, 1,2'd1,1,11,1));
        vecs.push_back(mk(1,0,12, 0,0,0,0, 0,2'd2,1,11,1));
        vecs.push_back(mk(1,0,13, 0,0,1,0, 1,2'd0,0, 0,0));
        vecs.push_back(mk(0,0, 0, 0,0,0,0, 1,2'd0,0, 0,0));

        // Reset state and first post-reset ready.
        tick();
        tick();
        chk("rst.ready", 32'(REQ_early_ready), 0);
        chk("rst.count", 32'(count), 0);
        chk("rst.deq_valid", 32'(deq_valid), 0);
        chk("rst.mq_pending", 32'(mq_pending), 0);
        chk("rst.deq_VPN", 32'(deq_VPN), 0);
        chk("rst.deq_cq", 32'(deq_cq_index), 0);
        RST = 1'b0;
        #1;
        chk("rst.ready_release", 32'(REQ_early_ready), 0);
        tick();
        chk("post_rst.ready", 32'(REQ_early_ready), 1);
        chk("post_rst.count", 32'(count), 0);

        // Table-driven vectors: inputs applied, one edge, then outputs checked.
        foreach (vecs[i]) begin
            REQ_valid      = vecs[i].valid;
            REQ_misaligned = vecs[i].mis;
            REQ_is_mq      = 1'b0;
            REQ_cq_index   = vecs[i].cq;
            REQ_VPN        = {16'hA5A5, vecs[i].cq};
            REQ_PO_word    = {6'h0, vecs[i].cq};
            REQ_byte_mask  = vecs[i].cq;
            bank_stall     = vecs[i].stall;
            mshr_full      = vecs[i].mshr;
            flush          = vecs[i].fl;
            deq_ready      = vecs[i].dr;
            tick();
            chk($sformatf("v%0d.ready", i), 32'(REQ_early_ready), 32'(vecs[i].exp_rdy));
            chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d.deq_valid", i), 32'(deq_valid), 32'(vecs[i].exp_dv));
            chk($sformatf("v%0d.mq_pending", i), 32'(mq_pending), 32'(vecs[i].exp_mq));
            if (vecs[i].exp_dv) begin
                chk($sformatf("v%0d.deq_cq", i), 32'(deq_cq_index), 32'(vecs[i].exp_cq));
                chk($sformatf("v%0d.deq_VPN", i), 32'(deq_VPN), {12'h0, 16'hA5A5, vecs[i].exp_cq});
            end
        end
        idle_inputs();

        // Misaligned pair: first half then its is_mq partner.
        REQ_valid = 1; REQ_misaligned = 1; REQ_is_mq = 0; REQ_VPN = 20'h12345;
        REQ_PO_word = 10'h3FF; REQ_byte_mask = 4'b1110; REQ_cq_index = 4'd4;
        tick();
        chk("mq.first.pending", 32'(mq_pending), 1);
        chk("mq.first.count", 32'(count), 1);
        chk("mq.first.VPN", 32'(deq_VPN), 32'h12345);
        chk("mq.first.PO", 32'(deq_PO_word), 32'h3FF);
        chk("mq.first.mask", 32'(deq_byte_mask), 32'hE);
        chk("mq.first.misaligned", 32'(deq_misaligned), 1);
        chk("mq.first.is_mq", 32'(deq_is_mq), 0);
        REQ_misaligned = 0; REQ_is_mq = 1; REQ_VPN = 20'h12346;
        REQ_PO_word = 10'h000; REQ_byte_mask = 4'b0001; REQ_cq_index = 4'd5;
        tick();
        chk("mq.second.pending", 32'(mq_pending), 0);
        chk("mq.second.count", 32'(count), 2);
        chk("mq.second.ready", 32'(REQ_early_ready), 0);
        idle_inputs();
        deq_ready = 1;
        tick();
        chk("mq.deq1.count", 32'(count), 1);
        chk("mq.deq1.VPN", 32'(deq_VPN), 32'h12346);
        chk("mq.deq1.PO", 32'(deq_PO_word), 0);
        chk("mq.deq1.mask", 32'(deq_byte_mask), 1);
        chk("mq.deq1.is_mq", 32'(deq_is_mq), 1);
        chk("mq.deq1.cq", 32'(deq_cq_index), 5);
        tick();
        chk("mq.deq2.count", 32'(count), 0);
        chk("mq.deq2.deq_valid", 32'(deq_valid), 0);
        deq_ready = 0;

        // Reset in the middle of operation discards buffered entries.
        REQ_valid = 1; REQ_cq_index = 4'd1; REQ_misaligned = 1;
        tick();
        chk("midrst.pre.count", 32'(count), 1);
        chk("midrst.pre.pending", 32'(mq_pending), 1);
        idle_inputs();
        RST = 1'b1;
        tick();
        chk("midrst.count", 32'(count), 0);
        chk("midrst.deq_valid", 32'(deq_valid), 0);
        chk("midrst.ready", 32'(REQ_early_ready), 0);
        chk("midrst.pending", 32'(mq_pending), 0);
        RST = 1'b0;
        tick();
        chk("midrst.post.ready", 32'(REQ_early_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
